// File: rtl/system_top.sv
// system_top: UART-controlled bring-up top.
// Receives 8N1 command bytes and drives a 10-bit LED register and a trigger
// level. Each command is answered over the UART transmit line.
//   sys_clk          in   system clock; all logic runs on the rising edge
//   sys_reset_n      in   asynchronous active-low reset
//   uart_rxd         in   UART receive line (idle high, asynchronous)
//   uart_txd         out  UART transmit line (idle high, registered)
//   gpio_led_tri_o   out  10-bit LED register
//   gpio_trig_tri_o  out  trigger level register
// Commands: 'L' x -> led[7:0]=x, 'H' x -> led[9:8]=x[1:0], 'T' toggles the
// trigger, 'R' returns led[7:0] then {6'b0,led[9:8]}. Every other opcode
// is answered with '?'. Bytes that arrive while a reply is being sent are
// dropped.
module system_top #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [9:0] gpio_led_tri_o,
  output logic       gpio_trig_tri_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {P_IDLE, P_ARG, P_RESP} p_state_e;

  // Receive path state
  logic          rx_meta_q, rx_meta_d;
  logic          rxs_q, rxs_d;
  logic          rxs_prev_q, rxs_prev_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;

  // Transmit path state
  logic          tx_busy_q, tx_busy_d;
  logic [8:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_pend_q, tx_pend_d;
  logic [7:0]    tx_pend_byte_q, tx_pend_byte_d;
  logic          txd_q, txd_d;
  logic          tx_done_s;

  // Parser state
  p_state_e      p_state_q, p_state_d;
  logic          arg_hi_q, arg_hi_d;
  logic [9:0]    led_q, led_d;
  logic          trig_q, trig_d;

  // Parser -> transmitter load request (combinational, one cycle)
  logic          tx_load_s;
  logic [7:0]    tx_load_byte_s;
  logic          tx_two_s;
  logic [7:0]    tx_byte2_s;

  // RX: synchroniser, start-bit qualification, mid-bit sampling
  always_comb begin
    rx_meta_d  = uart_rxd;
    rxs_d      = rx_meta_q;
    rxs_prev_d = rxs_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = CNT_ZERO;
        if (rxs_prev_q && !rxs_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        // Recheck the start bit half a bit after the falling edge.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = CNT_ZERO;
          rx_bit_d = 3'd0;
          if (!rxs_q) begin
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_shift_d = {rxs_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        // A low stop bit is a framing error: the byte is silently dropped.
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = CNT_ZERO;
          rx_state_d = RX_IDLE;
          if (rxs_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = rx_shift_q;
          end else begin
            rx_valid_d = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Parser: opcode decode, argument write, response selection
  always_comb begin
    p_state_d      = p_state_q;
    arg_hi_d       = arg_hi_q;
    led_d          = led_q;
    trig_d         = trig_q;
    tx_load_s      = 1'b0;
    tx_load_byte_s = 8'h00;
    tx_two_s       = 1'b0;
    tx_byte2_s     = 8'h00;
    case (p_state_q)
      P_IDLE: begin
        if (rx_valid_q) begin
          case (rx_byte_q)
            8'h4C: begin
              arg_hi_d  = 1'b0;
              p_state_d = P_ARG;
            end
            8'h48: begin
              arg_hi_d  = 1'b1;
              p_state_d = P_ARG;
            end
            8'h54: begin
              trig_d         = ~trig_q;
              tx_load_s      = 1'b1;
              tx_load_byte_s = 8'h4B;
              p_state_d      = P_RESP;
            end
            8'h52: begin
              // Both readback bytes are captured now, before any later write.
              tx_load_s      = 1'b1;
              tx_load_byte_s = led_q[7:0];
              tx_two_s       = 1'b1;
              tx_byte2_s     = {6'b000000, led_q[9:8]};
              p_state_d      = P_RESP;
            end
            default: begin
              tx_load_s      = 1'b1;
              tx_load_byte_s = 8'h3F;
              p_state_d      = P_RESP;
            end
          endcase
        end else begin
          p_state_d = P_IDLE;
        end
      end
      P_ARG: begin
        if (rx_valid_q) begin
          if (arg_hi_q) begin
            led_d[9:8] = rx_byte_q[1:0];
          end else begin
            led_d[7:0] = rx_byte_q;
          end
          tx_load_s      = 1'b1;
          tx_load_byte_s = 8'h4B;
          p_state_d      = P_RESP;
        end else begin
          p_state_d = P_ARG;
        end
      end
      P_RESP: begin
        if (tx_done_s) begin
          p_state_d = P_IDLE;
        end else begin
          p_state_d = P_RESP;
        end
      end
      default: begin
        p_state_d = P_IDLE;
      end
    endcase
  end

  // TX: 8N1 serialiser with one queued follow-on byte sent without a gap
  always_comb begin
    tx_busy_d      = tx_busy_q;
    tx_shift_d     = tx_shift_q;
    tx_bit_d       = tx_bit_q;
    tx_cnt_d       = tx_cnt_q;
    tx_pend_d      = tx_pend_q;
    tx_pend_byte_d = tx_pend_byte_q;
    txd_d          = txd_q;
    tx_done_s      = 1'b0;
    if (!tx_busy_q) begin
      if (tx_load_s) begin
        tx_busy_d      = 1'b1;
        txd_d          = 1'b0;
        tx_shift_d     = {1'b1, tx_load_byte_s};
        tx_bit_d       = 4'd0;
        tx_cnt_d       = CNT_ZERO;
        tx_pend_d      = tx_two_s;
        tx_pend_byte_d = tx_byte2_s;
      end else begin
        txd_d = 1'b1;
      end
    end else begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = CNT_ZERO;
        // tx_bit_q == 9 means the stop bit has just completed.
        if (tx_bit_q == 4'd9) begin
          if (tx_pend_q) begin
            txd_d      = 1'b0;
            tx_shift_d = {1'b1, tx_pend_byte_q};
            tx_bit_d   = 4'd0;
            tx_pend_d  = 1'b0;
          end else begin
            tx_busy_d = 1'b0;
            txd_d     = 1'b1;
            tx_done_s = 1'b1;
          end
        end else begin
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_ONE;
      end
    end
  end

  // State registers for RX, parser and TX
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      rx_meta_q      <= 1'b1;
      rxs_q          <= 1'b1;
      rxs_prev_q     <= 1'b1;
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= CNT_ZERO;
      rx_bit_q       <= 3'd0;
      rx_shift_q     <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_byte_q      <= 8'h00;
      tx_busy_q      <= 1'b0;
      tx_shift_q     <= 9'h1FF;
      tx_bit_q       <= 4'd0;
      tx_cnt_q       <= CNT_ZERO;
      tx_pend_q      <= 1'b0;
      tx_pend_byte_q <= 8'h00;
      txd_q          <= 1'b1;
      p_state_q      <= P_IDLE;
      arg_hi_q       <= 1'b0;
      led_q          <= 10'h000;
      trig_q         <= 1'b0;
    end else begin
      rx_meta_q      <= rx_meta_d;
      rxs_q          <= rxs_d;
      rxs_prev_q     <= rxs_prev_d;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_valid_q     <= rx_valid_d;
      rx_byte_q      <= rx_byte_d;
      tx_busy_q      <= tx_busy_d;
      tx_shift_q     <= tx_shift_d;
      tx_bit_q       <= tx_bit_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_pend_q      <= tx_pend_d;
      tx_pend_byte_q <= tx_pend_byte_d;
      txd_q          <= txd_d;
      p_state_q      <= p_state_d;
      arg_hi_q       <= arg_hi_d;
      led_q          <= led_d;
      trig_q         <= trig_d;
    end
  end

  assign uart_txd        = txd_q;
  assign gpio_led_tri_o  = led_q;
  assign gpio_trig_tri_o = trig_q;

endmodule

// File: tb/tb_system_top.sv
// tb_system_top: directed bench for system_top with CLKS_PER_BIT = 16.
// A serial monitor decodes uart_txd into a byte queue together with each
// byte's start-bit cycle. The main sequence sends command frames and
// compares the LED and trigger outputs and the decoded replies against
// hand-computed values.
module tb_system_top;

  localparam int CPB = 16;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_txd;
  logic [9:0] gpio_led_tri_o;
  logic       gpio_trig_tri_o;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  logic [7:0] rxq[$];
  int sq[$];

  system_top #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk(sys_clk),
    .sys_reset_n(sys_reset_n),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .gpio_led_tri_o(gpio_led_tri_o),
    .gpio_trig_tri_o(gpio_trig_tri_o)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serial monitor on uart_txd, sampling mid-bit on the falling clock edge.
  initial begin
    logic [7:0] b;
    int st;
    forever begin
      @(negedge sys_clk);
      if (sys_reset_n && uart_txd == 1'b0) begin
        st = cyc;
        repeat (CPB / 2) @(negedge sys_clk);
        if (uart_txd == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge sys_clk);
            b[i] = uart_txd;
          end
          repeat (CPB) @(negedge sys_clk);
          check("tx_stop_bit", {15'd0, uart_txd}, 16'd1);
          rxq.push_back(b);
          sq.push_back(st);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (CPB) @(posedge sys_clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(posedge sys_clk);
    uart_rxd = 1'b1;
    @(negedge sys_clk);
  endtask

  // Wait (bounded) for one decoded reply byte and compare it.
  task automatic get_tx(input string tag, input logic [7:0] exp, output int start_cyc);
    logic [8:0] got;
    int t;
    t = 0;
    while (rxq.size() == 0 && t < 800) begin
      @(negedge sys_clk);
      t++;
    end
    if (rxq.size() == 0) begin
      got = 9'h1FF;
      start_cyc = -1;
    end else begin
      got = {1'b0, rxq.pop_front()};
      start_cyc = sq.pop_front();
    end
    check(tag, {7'd0, got}, {8'd0, exp});
    repeat (CPB) @(negedge sys_clk);
  endtask

  initial begin
    int s0, s1, lows, t;

    // Reset: low for 3 cycles, then quiet line for 20 bit times.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    @(negedge sys_clk);
    check("rst_txd", {15'd0, uart_txd}, 16'd1);
    check("rst_led", {6'd0, gpio_led_tri_o}, 16'h000);
    check("rst_trig", {15'd0, gpio_trig_tri_o}, 16'd0);
    lows = 0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge sys_clk);
      if (uart_txd !== 1'b1) lows++;
    end
    check("rst_quiet", lows[15:0], 16'd0);

    // LED low write.
    send_byte(8'h4C, 1'b1);
    send_byte(8'hA5, 1'b1);
    check("led_lo", {6'd0, gpio_led_tri_o}, 16'h0A5);
    get_tx("ack_led_lo", 8'h4B, s0);

    // LED high write, then readback.
    send_byte(8'h48, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("led_hi", {6'd0, gpio_led_tri_o}, 16'h3A5);
    get_tx("ack_led_hi", 8'h4B, s0);
    send_byte(8'h52, 1'b1);
    get_tx("rd0", 8'hA5, s0);
    get_tx("rd1", 8'h03, s1);
    check("rd_gap", 16'(s1 - s0), 16'(10 * CPB));

    // Trigger toggles.
    send_byte(8'h54, 1'b1);
    check("trig_on", {15'd0, gpio_trig_tri_o}, 16'd1);
    get_tx("ack_trig1", 8'h4B, s0);
    send_byte(8'h54, 1'b1);
    check("trig_off", {15'd0, gpio_trig_tri_o}, 16'd0);
    get_tx("ack_trig2", 8'h4B, s0);

    // Unknown opcode.
    send_byte(8'h5A, 1'b1);
    get_tx("unknown", 8'h3F, s0);

    // Framing error inside ARG is dropped, ARG is kept.
    send_byte(8'h4C, 1'b1);
    send_byte(8'h77, 1'b0);
    repeat (CPB) @(negedge sys_clk);
    check("ferr_led", {6'd0, gpio_led_tri_o}, 16'h3A5);
    send_byte(8'h11, 1'b1);
    check("ferr_arg", {6'd0, gpio_led_tri_o}, 16'h311);
    get_tx("ferr_ack", 8'h4B, s0);
    repeat (12 * CPB) @(negedge sys_clk);
    check("ferr_single", 16'(rxq.size()), 16'd0);

    // Opcode arriving during a reply is ignored.
    send_byte(8'h52, 1'b1);
    send_byte(8'h4C, 1'b1);
    get_tx("busy_rd0", 8'h11, s0);
    get_tx("busy_rd1", 8'h03, s1);
    send_byte(8'h5A, 1'b1);
    get_tx("busy_drop", 8'h3F, s0);
    check("busy_led", {6'd0, gpio_led_tri_o}, 16'h311);

    // Reset during a reply and mid-RX frame.
    send_byte(8'h54, 1'b1);
    get_tx("ack_trig3", 8'h4B, s0);
    check("trig_pre_rst", {15'd0, gpio_trig_tri_o}, 16'd1);
    send_byte(8'h52, 1'b1);
    uart_rxd = 1'b0;
    repeat (CPB) @(posedge sys_clk);
    uart_rxd = 1'b1;
    repeat (CPB) @(posedge sys_clk);
    uart_rxd = 1'b0;
    t = 0;
    while (uart_txd !== 1'b0 && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    check("tx_low_pre_rst", {15'd0, uart_txd}, 16'd0);
    #2 sys_reset_n = 1'b0;
    #1;
    check("mid_rst_txd", {15'd0, uart_txd}, 16'd1);
    check("mid_rst_led", {6'd0, gpio_led_tri_o}, 16'h000);
    check("mid_rst_trig", {15'd0, gpio_trig_tri_o}, 16'd0);
    repeat (3) @(posedge sys_clk);
    uart_rxd = 1'b1;
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    repeat (30 * CPB) @(negedge sys_clk);
    rxq.delete();
    sq.delete();
    send_byte(8'h52, 1'b1);
    get_tx("post_rst_rd0", 8'h00, s0);
    get_tx("post_rst_rd1", 8'h00, s1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
